// File: rtl/alu_op_executor.sv
// ---------------------------------------------------------------------------
// alu_op_executor
//   Executes the operation chosen by the button-driven op-select FSM.
//   sel, a and b are captured on an accepted start pulse. ADD/SUB/AND/XOR/NOP
//   and DIV-by-zero finish after one execute cycle. MUL (shift-add) and DIV
//   (restoring) run WIDTH iteration cycles and then one execute cycle that
//   publishes the result.
//
//   Handshake: start is accepted at a posedge where busy=0 (state IDLE).
//   busy rises at the accept edge and falls at the edge that raises done.
//   done is a one-cycle pulse. result/remainder/div_by_zero change only at
//   done or reset. Because busy is already 0 in the done cycle, a start
//   presented in that cycle is accepted back-to-back. start while busy is
//   dropped, not queued.
//
// Ports
//   clk, reset    system clock; synchronous active-high reset
//   start         request pulse
//   sel[2:0]      000 NOP, 001 ADD, 010 SUB, 011 AND, 100 XOR, 101 MUL,
//                 110 DIV, 111 NOP
//   a, b          unsigned operands, WIDTH bits
//   busy          operation in progress
//   done          one-cycle completion pulse
//   result        2*WIDTH-bit result, held until the next done
//   remainder     DIV remainder, 0 for other ops
//   div_by_zero   set with done for DIV with b=0
//   state_dbg     current FSM state (IDLE=0, EXEC=1, MUL_IT=2, DIV_IT=3)
// ---------------------------------------------------------------------------
module alu_op_executor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           sel,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        MUL_IT = 2'd2,
        DIV_IT = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t               state_q,  state_d;
    logic [2:0]           op_q,     op_d;
    logic [WIDTH-1:0]     a_q,      a_d;
    logic [WIDTH-1:0]     b_q,      b_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    // multiplier working set: product accumulator, shifted multiplicand, multiplier bits
    logic [2*WIDTH-1:0]   prod_q,   prod_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    // divider working set: partial remainder and dividend/quotient shift register
    logic [WIDTH-1:0]     drem_q,   drem_d;
    logic [WIDTH-1:0]     dquo_q,   dquo_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]     rem_q,    rem_d;
    logic                 dbz_q,    dbz_d;

    // restoring-division step: shift in next dividend bit, try subtracting b
    logic [WIDTH:0]       div_trial;
    logic [WIDTH-1:0]     div_diff;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        drem_d   = drem_q;
        dquo_d   = dquo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;

        div_trial = {drem_q, dquo_q[WIDTH-1]};
        // only used when div_trial >= b, so the true difference fits WIDTH bits
        div_diff  = div_trial[WIDTH-1:0] - b_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = sel;
                    a_d      = a;
                    b_d      = b;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    prod_d   = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    drem_d   = '0;
                    dquo_d   = a;
                    if (sel == OP_MUL) begin
                        state_d = MUL_IT;
                    end else if (sel == OP_DIV && b != '0) begin
                        state_d = DIV_IT;
                    end else begin
                        // includes DIV by zero, which is resolved in one cycle
                        state_d = EXEC;
                    end
                end
            end

            MUL_IT: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end

            DIV_IT: begin
                if (div_trial >= {1'b0, b_q}) begin
                    drem_d = div_diff;
                    dquo_d = {dquo_q[WIDTH-2:0], 1'b1};
                end else begin
                    drem_d = div_trial[WIDTH-1:0];
                    dquo_d = {dquo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                // publish: every output field is rewritten at done
                result_d = '0;
                rem_d    = '0;
                dbz_d    = 1'b0;
                case (op_q)
                    OP_ADD: result_d[WIDTH:0]   = {1'b0, a_q} + {1'b0, b_q};
                    // the (WIDTH+1)-bit difference carries the borrow in its top bit
                    OP_SUB: result_d[WIDTH:0]   = {1'b0, a_q} - {1'b0, b_q};
                    OP_AND: result_d[WIDTH-1:0] = a_q & b_q;
                    OP_XOR: result_d[WIDTH-1:0] = a_q ^ b_q;
                    OP_MUL: result_d            = prod_q;
                    OP_DIV: begin
                        if (b_q == '0) begin
                            result_d[WIDTH-1:0] = '1;
                            rem_d               = a_q;
                            dbz_d               = 1'b1;
                        end else begin
                            result_d[WIDTH-1:0] = dquo_q;
                            rem_d               = drem_q;
                        end
                    end
                    default: result_d = '0;
                endcase
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            drem_q   <= '0;
            dquo_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            drem_q   <= drem_d;
            dquo_q   <= dquo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_alu_op_executor.sv
// Testbench for alu_op_executor (WIDTH=4).
// Driver issues operations at negedges; each issue pushes the reference
// result and the cycle at which done must appear. A monitor pops on every
// done and compares.
module tb_alu_op_executor;

  localparam int W  = 4;
  localparam int EW = 3 * W + 1;  // {div_by_zero, remainder, result}

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2:0]     sel;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic [1:0]     state_dbg;

  alu_op_executor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .remainder(remainder),
    .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            n_vectors = 0;
  int            n_checks  = 0;
  int            n_errors  = 0;
  int            n_done    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic rules, not the datapath.
  function automatic logic [EW-1:0] model(input logic [2:0] s, input int av, input int bv);
    logic [EW-1:0] v;
    int r;
    int rem;
    bit dz;
    r = 0; rem = 0; dz = 0;
    case (s)
      3'd1: r = av + bv;
      3'd2: r = (av < bv) ? ((av - bv + (1 << W)) + (1 << W)) : (av - bv);
      3'd3: r = av & bv;
      3'd4: r = av ^ bv;
      3'd5: r = av * bv;
      3'd6: begin
        if (bv == 0) begin
          r = (1 << W) - 1; rem = av; dz = 1;
        end else begin
          r = av / bv; rem = av % bv;
        end
      end
      default: r = 0;
    endcase
    v = '0;
    v[2*W-1:0]   = r[2*W-1:0];
    v[3*W-1:2*W] = rem[W-1:0];
    v[3*W]       = dz;
    return v;
  endfunction

  function automatic int latency(input logic [2:0] s, input int bv);
    if (s == 3'd5 || (s == 3'd6 && bv != 0)) return W + 1;
    return 1;
  endfunction

  // ---------------- driver ----------------
  // Called and returns at a negedge. Waits for busy=0, presents the op for one
  // edge, then scrambles the inputs so any late sampling shows up.
  task automatic issue(input logic [2:0] s, input logic [W-1:0] av, input logic [W-1:0] bv);
    int guard;
    int k;
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL issue_timeout: busy stuck at %b, expected 0", busy);
    end
    start = 1'b1; sel = s; a = av; b = bv;
    k = cyc + 1;
    exp_q.push_back(model(s, int'(av), int'(bv)));
    exp_cyc_q.push_back(k + latency(s, int'(bv)));
    n_vectors++;
    @(negedge clk);
    start = 1'b0;
    sel = 3'($urandom_range(0, 7));
    a = W'($urandom_range(0, (1 << W) - 1));
    b = W'($urandom_range(0, (1 << W) - 1));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int c;
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("result",      32'(result),      32'(e[2*W-1:0]));
        check("remainder",   32'(remainder),   32'(e[3*W-1:2*W]));
        check("div_by_zero", 32'(div_by_zero), 32'(e[3*W]));
        check("done_cycle",  32'(cyc),         32'(c));
        check("busy_in_done", 32'(busy),       32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    reset = 1'b1; start = 1'b0; sel = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(busy),        32'd0);
    check("reset_done",   32'(done),        32'd0);
    check("reset_result", 32'(result),      32'd0);
    check("reset_rem",    32'(remainder),   32'd0);
    check("reset_dbz",    32'(div_by_zero), 32'd0);
    check("reset_state",  32'(state_dbg),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed corner cases
    issue(3'd1, 4'hF, 4'h1);   // ADD with carry -> 0x10
    issue(3'd2, 4'h3, 4'h5);   // SUB with borrow -> 0x1E
    issue(3'd5, 4'hF, 4'hF);   // MUL -> 0xE1, inputs scrambled after accept
    for (int i = 0; i < W; i++) begin
      check("mul_busy_window", 32'(busy), 32'd1);
      @(negedge clk);
    end
    issue(3'd6, 4'hD, 4'h4);   // DIV -> q=3 r=1
    issue(3'd6, 4'h9, 4'h0);   // DIV by zero -> 0x0F, rem 9, dbz
    issue(3'd3, 4'hC, 4'hA);   // AND clears remainder/dbz
    issue(3'd0, 4'h7, 4'h7);   // NOP
    issue(3'd7, 4'h7, 4'h7);   // NOP
    issue(3'd4, 4'hC, 4'hA);   // XOR
    issue(3'd5, 4'h0, 4'h9);   // MUL by zero operand
    issue(3'd6, 4'h3, 4'hF);   // DIV a<b -> q=0 r=3
    issue(3'd6, 4'hF, 4'h1);   // DIV by one

    // start re-pulsed during MUL must be dropped
    issue(3'd5, 4'hA, 4'h7);
    start = 1'b1; sel = 3'd1; a = 4'h1; b = 4'h1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;

    // reset sampled at edge k+2 of a MUL aborts it without a done
    issue(3'd5, 4'h6, 4'h7);   // returns after edge k
    @(negedge clk);            // after edge k+1
    reset = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clk);            // after edge k+2
    check("abort_busy",   32'(busy),        32'd0);
    check("abort_done",   32'(done),        32'd0);
    check("abort_result", 32'(result),      32'd0);
    check("abort_rem",    32'(remainder),   32'd0);
    check("abort_dbz",    32'(div_by_zero), 32'd0);
    check("abort_state",  32'(state_dbg),   32'd0);
    reset = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    issue(3'd1, 4'h2, 4'h3);

    // randomized traffic with random idle gaps (gap 0 gives back-to-back)
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(3'($urandom_range(0, 7)),
            W'($urandom_range(0, (1 << W) - 1)),
            W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, (1 << W) - 1)));
    end

    // drain
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("done_count", 32'(n_done), 32'(n_vectors - 1));  // one op aborted by reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
    $finish;
  end

endmodule
